multibuf_packetmem: RTL

Parametrised, multi-buffered packet memory for the BPF filter datapath. A packet source fills one buffer with full-width big-endian words. The BPF CPU reads a different, completed buffer with byte-addressed, possibly unaligned byte/half-word/word loads. Buffers circulate round-robin under an explicit ownership handshake, so filling and filtering overlap. Each completed buffer carries its packet length, and any load past that length is flagged.

---
 rtl/multibuf_packetmem_if.sv | 31 +++
 rtl/multibuf_packetmem.sv | 82 ++++++++
 2 files changed

// File: rtl/multibuf_packetmem_if.sv
// multibuf_packetmem_if: packet-source write port and BPF-CPU load port of the packet memory
interface multibuf_packetmem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  localparam int BYTE_ADDR_WIDTH = ADDR_WIDTH + $clog2(DATA_WIDTH / 8);
  localparam int LEN_WIDTH = BYTE_ADDR_WIDTH + 1;
  logic                       wr_ready;
  logic [ADDR_WIDTH-1:0]      wr_addr;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic                       wr_en;
  logic                       wr_done;
  logic [LEN_WIDTH-1:0]       wr_len;
  logic                       rd_ready;
  logic [BYTE_ADDR_WIDTH-1:0] rd_addr;
  logic [1:0]                 sz;
  logic                       rd_en;
  logic [31:0]                rd_data;
  logic                       rd_valid;
  logic                       rd_oob;
  logic [LEN_WIDTH-1:0]       rd_len;
  logic                       rd_release;
  modport master (
    input  wr_ready, rd_ready, rd_data, rd_valid, rd_oob, rd_len,
    output wr_addr, wr_data, wr_en, wr_done, wr_len, rd_addr, sz, rd_en, rd_release
  );
  modport slave (
    output wr_ready, rd_ready, rd_data, rd_valid, rd_oob, rd_len,
    input  wr_addr, wr_data, wr_en, wr_done, wr_len, rd_addr, sz, rd_en, rd_release
  );
endinterface

// File: rtl/multibuf_packetmem.sv
// multibuf_packetmem: round-robin multi-buffered packet memory with unaligned big-endian byte loads
module multibuf_packetmem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BUFS   = 2
) (
  input logic clk,
  input logic rst_n,
  multibuf_packetmem_if.slave bus
);
  localparam int BW    = $clog2(DATA_WIDTH / 8);
  localparam int BAW   = ADDR_WIDTH + BW;
  localparam int LW    = BAW + 1;
  localparam int PW    = $clog2(NUM_BUFS);
  localparam int HW    = ADDR_WIDTH - 1;
  localparam int DEPTH = NUM_BUFS << HW;
  localparam logic [LW-1:0] CAP = {1'b1, {BAW{1'b0}}};
  logic [DATA_WIDTH-1:0]   mem_even [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_odd  [DEPTH];
  logic [NUM_BUFS-1:0]     full;
  logic [LW-1:0]           len [NUM_BUFS];
  logic [PW-1:0]           wbuf, rbuf;
  logic [ADDR_WIDTH-1:0]   widx;
  logic [BW-1:0]           boff;
  logic [HW-1:0]           even_idx, odd_idx;
  logic [DATA_WIDTH-1:0]   word_even, word_odd;
  logic [2*DATA_WIDTH-1:0] pair, shifted;
  logic [31:0]             load;
  logic [2:0]              nbytes;
  logic [LW:0]             end_byte;
  logic                    oob;
  assign bus.wr_ready = !full[wbuf];
  assign bus.rd_ready = full[rbuf];
  assign bus.rd_len   = full[rbuf] ? len[rbuf] : '0;
  // An odd start word pairs with the next even word; that even index wraps at the buffer end.
  always_comb begin
    widx      = bus.rd_addr[BAW-1:BW];
    boff      = bus.rd_addr[BW-1:0];
    odd_idx   = widx[ADDR_WIDTH-1:1];
    even_idx  = odd_idx + HW'(widx[0]);
    word_even = mem_even[{rbuf, even_idx}];
    word_odd  = mem_odd[{rbuf, odd_idx}];
    pair      = widx[0] ? {word_odd, word_even} : {word_even, word_odd};
    shifted   = pair << {boff, 3'b000};
    load      = bus.sz == 2'b00 ? shifted[2*DATA_WIDTH-1 -: 32]
              : bus.sz == 2'b01 ? {16'h0, shifted[2*DATA_WIDTH-1 -: 16]}
              : {24'h0, shifted[2*DATA_WIDTH-1 -: 8]};
    nbytes    = bus.sz == 2'b00 ? 3'd4 : bus.sz == 2'b01 ? 3'd2 : 3'd1;
    end_byte  = (LW+1)'(bus.rd_addr) + (LW+1)'(nbytes);
    oob       = bus.sz == 2'b11 || !bus.rd_ready || end_byte > {1'b0, bus.rd_len};
  end
  always_ff @(posedge clk) begin
    if (bus.wr_en && bus.wr_ready) begin
      if (bus.wr_addr[0]) mem_odd[{wbuf, bus.wr_addr[ADDR_WIDTH-1:1]}] <= bus.wr_data;
      else mem_even[{wbuf, bus.wr_addr[ADDR_WIDTH-1:1]}] <= bus.wr_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full         <= '0;
      wbuf         <= '0;
      rbuf         <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_oob   <= 1'b0;
      for (int i = 0; i < NUM_BUFS; i++) len[i] <= '0;
    end else begin
      if (bus.wr_done && bus.wr_ready) begin
        full[wbuf] <= 1'b1;
        len[wbuf]  <= bus.wr_len > CAP ? CAP : bus.wr_len;
        wbuf       <= wbuf + PW'(1);
      end
      if (bus.rd_release && bus.rd_ready) begin
        full[rbuf] <= 1'b0;
        rbuf       <= rbuf + PW'(1);
      end
      bus.rd_valid <= bus.rd_en;
      bus.rd_oob   <= bus.rd_en && oob;
      bus.rd_data  <= bus.rd_en && !oob ? load : '0;
    end
  end
endmodule
